wah_sequencer: RTL and testbench
================================

# wah_sequencer

Per-sample control sequencer for the wah effect datapath. Derives the 96 kHz sample tick from `system_clock` (96 MHz) and, once per sample, steps the datapath through envelope update, cutoff computation, coefficient load, a time-multiplexed multiply-accumulate over the filter taps, and output latch. It owns the single shared MAC's tap select and clear/enable controls. It also reports frames that fail to complete before the next tick.

## Interface
Parameters:
- `CLK_DIV`, 1000: `system_clock` cycles per sample tick (96 MHz / 96 kHz).
- `NUM_TAPS`, 5: MAC steps per sample (b0, b1, b2, a1, a2); legal range 1..8.
- `CUTOFF_TIMEOUT`, 64: maximum `CUTOFF` wait in cycles; used only with `WAH_SEQ_TIMEOUT_EN`.

Ports:
- `system_clock`  in  1  96 MHz system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  when high, each tick starts a frame.
- `cutoff_ack`  in  1  cutoff unit result valid; sampled only in `CUTOFF`.
- `sample_tick`  out  1  one-cycle pulse every `CLK_DIV` cycles.
- `env_en`  out  1  envelope analyzer update strobe.
- `cutoff_req`  out  1  level request to the cutoff unit.
- `coef_load`  out  1  filter coefficient register load strobe.
- `mac_clear`  out  1  clear accumulator (first tap only).
- `mac_en`  out  1  accumulate this cycle.
- `tap_sel`  out  3  tap index driving the MAC operand muxes.
- `out_latch`  out  1  latch accumulator into `filter_out`.
- `busy`  out  1  FSM not in `IDLE`.
- `overrun`  out  1  sticky: a tick arrived while busy.
- `overrun_count`  out  8  count of ticks dropped; saturates at 255.

## Operation
- Tick counter runs 0..`CLK_DIV`-1, then wraps to 0. It runs regardless of `enable`. `sample_tick` is high when count == `CLK_DIV`-1.
- FSM states: `IDLE`, `ENV`, `CUTOFF`, `COEF`, `MAC`, `OUT`.
- `IDLE`: go to `ENV` on `sample_tick && enable`.
- `ENV`: `env_en`=1 for one cycle, then go to `CUTOFF`.
- `CUTOFF`: `cutoff_req`=1 while in this state. When `cutoff_ack`=1, go to `COEF`. An ack in the first `CUTOFF` cycle is legal.
- `COEF`: `coef_load`=1 for one cycle, then go to `MAC`.
- `MAC`: lasts `NUM_TAPS` cycles.
  - `mac_en`=1 on every cycle.
  - `tap_sel` counts 0..`NUM_TAPS`-1.
  - `mac_clear`=1 only when `tap_sel`==0.
  - After the last tap, go to `OUT`.
- `OUT`: `out_latch`=1 for one cycle, then go to `IDLE`.
- Outside `MAC`, `tap_sel`=0. All strobes are zero outside their own state.
- `sample_tick` while FSM not in `IDLE`:
  - The tick is dropped; the current frame continues undisturbed.
  - Set `overrun`. Increment `overrun_count`, saturating at 255.
  - A tick landing on the `OUT` cycle counts as an overrun; no back-to-back frame starts.
- `enable` deasserted mid-frame: the frame completes; no new frame starts.
- Only `rst` clears `overrun` and `overrun_count`.

## Timing
- All outputs are registered.
- Reset values: every output 0, tick counter 0, FSM in `IDLE`. Reset applies at the first edge with `rst`=1, including mid-frame; that frame is abandoned with no further strobes.
- First `sample_tick` after reset release: cycle `CLK_DIV`-1.
- Frame timeline, with tick at cycle T and ack in the first `CUTOFF` cycle:
  - `env_en` at T+1
  - `cutoff_req` at T+2
  - `coef_load` at T+3
  - `mac_en` at T+4..T+3+`NUM_TAPS`
  - `out_latch` at T+4+`NUM_TAPS` (T+9 for `NUM_TAPS`=5)
- Each cycle of ack delay adds one cycle to every step after `CUTOFF`.
- `cutoff_req` falls in the cycle after ack is seen.

## Configuration
- `WAH_SEQ_TIMEOUT_EN` defined:
  - Leave `CUTOFF` once `CUTOFF_TIMEOUT` cycles pass with no ack.
  - On timeout, skip `COEF`, go directly to `MAC` (previous coefficients reused), and set sticky output `cutoff_timeout` (1 bit, reset 0).
- `WAH_SEQ_TIMEOUT_EN` undefined: wait indefinitely for ack; `cutoff_timeout` port absent.

## Structure
- `wah_pkg` holds:
  - the `wah_seq_state_t` enum
  - `TAP_IDX_W`=3
  - `WAH_CLK_DIV_DEFAULT`=1000
  - `OVERRUN_CNT_W`=8
- One sub-module: `sample_tick_gen` (parameter `CLK_DIV`, ports `system_clock`, `rst`, output `sample_tick`), containing the tick counter.

## Test plan
- Reset, `enable`=1, ack tied high, `CLK_DIV`=1000 -> ticks at cycles 999 and 1999. Frame strobes at T+1, T+2, T+3, T+4..T+8, T+9. `tap_sel` steps 0,1,2,3,4; `mac_clear` only with tap 0.
- Ack delayed 10 cycles -> `cutoff_req` high for 11 cycles; `out_latch` at T+19; `overrun` stays 0.
- `CLK_DIV`=8, ack never returned (macro off) -> FSM held in `CUTOFF`. `overrun_count` reaches 1, 2, …, 255 and holds at 255.
- `rst` asserted at T+5 -> all outputs 0 next cycle. Next frame starts only at the following tick with full sequence.
- `enable` dropped at T+3 -> current frame finishes (`out_latch` at T+9); no `env_en` at next tick.
- `WAH_SEQ_TIMEOUT_EN`, `CUTOFF_TIMEOUT`=64, no ack -> `MAC` starts at T+66, no `coef_load`, `cutoff_timeout`=1.

Source files
------------

// File: rtl/wah_pkg.sv
// -----------------------------------------------------------------------------
// wah_pkg
// Shared types and constants for the wah effect control sequencer.
//   wah_seq_state_t     : per-sample frame FSM states
//   TAP_IDX_W           : width of the MAC tap index
//   WAH_CLK_DIV_DEFAULT : system_clock cycles per sample (96 MHz / 96 kHz)
//   OVERRUN_CNT_W       : width of the saturating dropped-tick counter
// -----------------------------------------------------------------------------
package wah_pkg;

  localparam int TAP_IDX_W           = 3;
  localparam int WAH_CLK_DIV_DEFAULT = 1000;
  localparam int OVERRUN_CNT_W       = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ENV    = 3'd1,
    CUTOFF = 3'd2,
    COEF   = 3'd3,
    MAC    = 3'd4,
    OUT    = 3'd5
  } wah_seq_state_t;

endpackage

// File: rtl/wah_sequencer_sample_tick_gen.sv
// -----------------------------------------------------------------------------
// sample_tick_gen
// Divides system_clock down to the audio sample rate. The counter runs
// 0..CLK_DIV-1 and wraps; sample_tick is a registered one-cycle pulse that is
// high exactly while the count equals CLK_DIV-1.
// Ports:
//   system_clock : in  1  the only clock
//   rst          : in  1  synchronous, active-high reset (count and tick to 0)
//   sample_tick  : out 1  one-cycle pulse every CLK_DIV cycles
// -----------------------------------------------------------------------------
module sample_tick_gen
  import wah_pkg::*;
#(
  parameter int CLK_DIV = WAH_CLK_DIV_DEFAULT
) (
  input  logic system_clock,
  input  logic rst,
  output logic sample_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LAST) cnt_d = '0;
  end

  // The tick flop looks at the next count so that it lines up with cnt_q.
  always_ff @(posedge system_clock) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == LAST);
    end
  end

  assign sample_tick = tick_q;

endmodule

// File: rtl/wah_sequencer.sv
// -----------------------------------------------------------------------------
// wah_sequencer
// Per-sample control sequencer for the wah datapath. Every sample tick (when
// enabled) it walks ENV -> CUTOFF -> COEF -> MAC x NUM_TAPS -> OUT, driving the
// strobes and the shared MAC's tap select / clear / enable. Ticks that arrive
// while a frame is still in flight are dropped and reported.
// Optional feature macro: WAH_SEQ_TIMEOUT_EN -- bounds the CUTOFF wait to
// CUTOFF_TIMEOUT cycles; on expiry COEF is skipped (old coefficients reused)
// and the sticky cutoff_timeout output is set.
// Ports:
//   system_clock  : in  1  96 MHz clock
//   rst           : in  1  synchronous, active-high reset
//   enable        : in  1  allow a tick to start a frame
//   cutoff_ack    : in  1  cutoff result valid (looked at only in CUTOFF)
//   sample_tick   : out 1  one-cycle pulse every CLK_DIV cycles
//   env_en        : out 1  envelope update strobe
//   cutoff_req    : out 1  level request to the cutoff unit
//   coef_load     : out 1  coefficient register load strobe
//   mac_clear     : out 1  clear accumulator (tap 0)
//   mac_en        : out 1  accumulate this cycle
//   tap_sel       : out 3  MAC tap index (0 outside MAC)
//   out_latch     : out 1  latch accumulator into the filter output
//   busy          : out 1  a frame is in flight
//   overrun       : out 1  sticky: a tick was dropped
//   overrun_count : out 8  dropped ticks, saturating at 255
//   cutoff_timeout: out 1  (WAH_SEQ_TIMEOUT_EN only) sticky CUTOFF timeout
// All outputs are registered.
// -----------------------------------------------------------------------------
module wah_sequencer
  import wah_pkg::*;
#(
  parameter int CLK_DIV        = WAH_CLK_DIV_DEFAULT,
  parameter int NUM_TAPS       = 5,
  parameter int CUTOFF_TIMEOUT = 64
) (
  input  logic                     system_clock,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     cutoff_ack,
  output logic                     sample_tick,
  output logic                     env_en,
  output logic                     cutoff_req,
  output logic                     coef_load,
  output logic                     mac_clear,
  output logic                     mac_en,
  output logic [TAP_IDX_W-1:0]     tap_sel,
  output logic                     out_latch,
  output logic                     busy,
  output logic                     overrun,
  output logic [OVERRUN_CNT_W-1:0] overrun_count
`ifdef WAH_SEQ_TIMEOUT_EN
  ,
  output logic                     cutoff_timeout
`endif
);

  if (NUM_TAPS < 1 || NUM_TAPS > 8 || CUTOFF_TIMEOUT < 1) begin : g_param_check
    $error("wah_sequencer: NUM_TAPS must be 1..8 and CUTOFF_TIMEOUT >= 1");
  end

  wah_seq_state_t             state_q, state_d;
  logic [TAP_IDX_W-1:0]       tap_q, tap_d;
  logic                       ovr_q, ovr_d;
  logic [OVERRUN_CNT_W-1:0]   ocnt_q, ocnt_d;
  logic                       env_q, req_q, coef_q, clr_q, mac_q, out_q, busy_q;
  logic                       drop_tick;

`ifdef WAH_SEQ_TIMEOUT_EN
  localparam int WAIT_W = $clog2(CUTOFF_TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              tmo_q, tmo_d;
`endif

  sample_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .system_clock(system_clock),
    .rst         (rst),
    .sample_tick (sample_tick)
  );

  // A tick seen in any non-IDLE state (including the OUT cycle) is dropped.
  assign drop_tick = sample_tick && (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    tap_d   = '0;
`ifdef WAH_SEQ_TIMEOUT_EN
    wait_d  = '0;
    tmo_d   = tmo_q;
`endif
    case (state_q)
      IDLE:    if (sample_tick && enable) state_d = ENV;
      ENV:     state_d = CUTOFF;
      CUTOFF: begin
        if (cutoff_ack) begin
          state_d = COEF;
`ifdef WAH_SEQ_TIMEOUT_EN
        end else if (wait_q == WAIT_W'(CUTOFF_TIMEOUT - 1)) begin
          // No fresh cutoff: keep the previous coefficients and go straight on.
          state_d = MAC;
          tmo_d   = 1'b1;
        end else begin
          wait_d  = wait_q + 1'b1;
`endif
        end
      end
      COEF:    state_d = MAC;
      MAC: begin
        if (tap_q == TAP_IDX_W'(NUM_TAPS - 1)) state_d = OUT;
        else                                    tap_d   = tap_q + 1'b1;
      end
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ovr_d  = ovr_q | drop_tick;
    ocnt_d = ocnt_q;
    if (drop_tick && (ocnt_q != '1)) ocnt_d = ocnt_q + 1'b1;
  end

  // Output flops are loaded from the next-state decode so every strobe lines
  // up with the state it belongs to.
  always_ff @(posedge system_clock) begin
    if (rst) begin
      state_q <= IDLE;
      tap_q   <= '0;
      env_q   <= 1'b0;
      req_q   <= 1'b0;
      coef_q  <= 1'b0;
      clr_q   <= 1'b0;
      mac_q   <= 1'b0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      ocnt_q  <= '0;
`ifdef WAH_SEQ_TIMEOUT_EN
      wait_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      env_q   <= (state_d == ENV);
      req_q   <= (state_d == CUTOFF);
      coef_q  <= (state_d == COEF);
      clr_q   <= (state_d == MAC) && (tap_d == '0);
      mac_q   <= (state_d == MAC);
      out_q   <= (state_d == OUT);
      busy_q  <= (state_d != IDLE);
      ovr_q   <= ovr_d;
      ocnt_q  <= ocnt_d;
`ifdef WAH_SEQ_TIMEOUT_EN
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign env_en        = env_q;
  assign cutoff_req    = req_q;
  assign coef_load     = coef_q;
  assign mac_clear     = clr_q;
  assign mac_en        = mac_q;
  assign tap_sel       = tap_q;
  assign out_latch     = out_q;
  assign busy          = busy_q;
  assign overrun       = ovr_q;
  assign overrun_count = ocnt_q;
`ifdef WAH_SEQ_TIMEOUT_EN
  assign cutoff_timeout = tmo_q;
`endif

endmodule

// File: tb/tb_wah_sequencer.sv
// -----------------------------------------------------------------------------
// tb_wah_sequencer
// Two instances: u_dut (CLK_DIV=1000) exercises the frame timeline under
// directed and random ack/enable stimulus; u_dut8 (CLK_DIV=8, ack never
// returned) exercises overrun counting and saturation. Expected outputs come
// from a timeline model: each frame is described by its tick cycle and the
// cycle its CUTOFF wait ended, and every strobe is derived from those with
// plain arithmetic.
// -----------------------------------------------------------------------------
module tb_wah_sequencer;

  localparam int NT = 5;
  localparam int TO = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, en0, ack0, rst1, en1, ack1;
  logic st0, env0, req0, coef0, clr0, mac0, out0, busy0, ovr0, tmo0;
  logic st1, env1, req1, coef1, clr1, mac1, out1, busy1, ovr1, tmo1;
  logic [2:0] tap0, tap1;
  logic [7:0] cnt0, cnt1;

  wah_sequencer #(.CLK_DIV(1000), .NUM_TAPS(NT), .CUTOFF_TIMEOUT(TO)) u_dut (
    .system_clock(clk), .rst(rst0), .enable(en0), .cutoff_ack(ack0),
    .sample_tick(st0), .env_en(env0), .cutoff_req(req0), .coef_load(coef0),
    .mac_clear(clr0), .mac_en(mac0), .tap_sel(tap0), .out_latch(out0),
    .busy(busy0), .overrun(ovr0), .overrun_count(cnt0)
`ifdef WAH_SEQ_TIMEOUT_EN
    , .cutoff_timeout(tmo0)
`endif
  );

  wah_sequencer #(.CLK_DIV(8), .NUM_TAPS(NT), .CUTOFF_TIMEOUT(TO)) u_dut8 (
    .system_clock(clk), .rst(rst1), .enable(en1), .cutoff_ack(ack1),
    .sample_tick(st1), .env_en(env1), .cutoff_req(req1), .coef_load(coef1),
    .mac_clear(clr1), .mac_en(mac1), .tap_sel(tap1), .out_latch(out1),
    .busy(busy1), .overrun(ovr1), .overrun_count(cnt1)
`ifdef WAH_SEQ_TIMEOUT_EN
    , .cutoff_timeout(tmo1)
`endif
  );

`ifndef WAH_SEQ_TIMEOUT_EN
  assign tmo0 = 1'b0;
  assign tmo1 = 1'b0;
  localparam int NF = 11;
`else
  localparam int NF = 12;
`endif

  logic [20:0] v0, v1;
  assign v0 = {st0, env0, req0, coef0, clr0, mac0, tap0, out0, busy0, ovr0, cnt0, tmo0};
  assign v1 = {st1, env1, req1, coef1, clr1, mac1, tap1, out1, busy1, ovr1, cnt1, tmo1};

  string fname[12] = '{"sample_tick", "env_en", "cutoff_req", "coef_load", "mac_clear",
                       "mac_en", "tap_sel", "out_latch", "busy", "overrun",
                       "overrun_count", "cutoff_timeout"};
  int    flsb[12]  = '{20, 19, 18, 17, 16, 15, 12, 11, 10, 9, 1, 0};
  int    fw[12]    = '{1, 1, 1, 1, 1, 1, 3, 1, 1, 1, 8, 1};

  // Timeline model state, one slot per instance.
  int DIVS[2] = '{1000, 8};
  int mc[2], mT[2], mCE[2], mcnt[2];
  bit mskip[2], movr[2], mtmo[2];

  // Stimulus knobs for u_dut.
  int dly0 = 0, dly_fix = 0;
  bit dly_rand = 0, en_rand = 0, en_fix = 1;

  // Observed event cycles on u_dut.
  int last_env = -1, last_out = -1, last_tick = -1, last_macs = -1, last_coef = -1;
  int req_cnt = 0;

  int n_assert = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic mreset(input int i);
    mc[i] = 0; mT[i] = -1; mCE[i] = -1; mcnt[i] = 0;
    mskip[i] = 0; movr[i] = 0; mtmo[i] = 0;
  endtask

  function automatic int mac_start(input int i);
    return mCE[i] + (mskip[i] ? 1 : 2);
  endfunction

  function automatic bit in_cut(input int i);
    return mT[i] >= 0 && mc[i] >= mT[i] + 2 && (mCE[i] < 0 || mc[i] <= mCE[i]);
  endfunction

  function automatic bit m_busy(input int i);
    return mT[i] >= 0 && mc[i] >= mT[i] + 1 && (mCE[i] < 0 || mc[i] <= mac_start(i) + NT);
  endfunction

  function automatic bit m_out(input int i);
    return mT[i] >= 0 && mCE[i] >= 0 && mc[i] == mac_start(i) + NT;
  endfunction

  function automatic logic [20:0] mexp(input int i);
    int c, fm, tap;
    bit act, ce, env, coef, mac, tick;
    c    = mc[i];
    fm   = mac_start(i);
    act  = mT[i] >= 0;
    ce   = mCE[i] >= 0;
    env  = act && c == mT[i] + 1;
    coef = act && ce && !mskip[i] && c == mCE[i] + 1;
    mac  = act && ce && c >= fm && c <= fm + NT - 1;
    tap  = mac ? c - fm : 0;
    tick = (c % DIVS[i]) == DIVS[i] - 1;
    return {tick, env, in_cut(i), coef, mac && tap == 0, mac, 3'(tap), m_out(i),
            m_busy(i), movr[i], 8'(mcnt[i]), mtmo[i]};
  endfunction

  task automatic mupd(input int i, input bit ack, input bit en);
    bit tick, bsy, cut, ol;
    tick = (mc[i] % DIVS[i]) == DIVS[i] - 1;
    bsy  = m_busy(i);
    cut  = in_cut(i);
    ol   = m_out(i);
    if (cut && ack) begin
      mCE[i] = mc[i]; mskip[i] = 0;
    end
`ifdef WAH_SEQ_TIMEOUT_EN
    else if (cut && mc[i] == mT[i] + 1 + TO) begin
      mCE[i] = mc[i]; mskip[i] = 1; mtmo[i] = 1;
    end
`endif
    if (ol) begin
      mT[i] = -1; mCE[i] = -1;
    end
    if (tick) begin
      if (bsy) begin
        movr[i] = 1;
        if (mcnt[i] < 255) mcnt[i]++;
      end else if (en) begin
        mT[i] = mc[i]; mCE[i] = -1;
        if (i == 0) dly0 = dly_rand ? int'($urandom_range(0, 30)) : dly_fix;
      end
    end
    mc[i]++;
  endtask

  // One cycle: check both instances, drive inputs, advance models, move to the
  // next falling edge.
  task automatic step(input bit rst0_req);
    logic [20:0] e, vx;
    logic [31:0] o, x;
    bit a0, e0;
    for (int i = 0; i < 2; i++) begin
      e  = mexp(i);
      vx = (i == 0) ? v0 : v1;
      for (int f = 0; f < NF; f++) begin
        o = '0; x = '0;
        for (int b = 0; b < fw[f]; b++) begin
          o[b] = vx[flsb[f] + b];
          x[b] = e[flsb[f] + b];
        end
        chk((i == 0) ? fname[f] : {fname[f], "_div8"}, o, x);
      end
    end
    if (env0) begin last_env = mc[0]; req_cnt = 0; end
    if (req0) req_cnt++;
    if (out0) last_out = mc[0];
    if (st0) last_tick = mc[0];
    if (mac0 && clr0) last_macs = mc[0];
    if (coef0) last_coef = mc[0];
    if (mT[0] >= 0) a0 = (mc[0] >= mT[0] + 2 + dly0);
    else            a0 = 1'($urandom % 2);
    e0 = en_rand ? ($urandom % 4 != 0) : en_fix;
    ack0 = a0; en0 = e0; rst0 = rst0_req;
    ack1 = 1'b0; en1 = 1'b1; rst1 = 1'b0;
    if (!rst0_req) mupd(0, a0, e0);
    mupd(1, 1'b0, 1'b1);
    @(negedge clk);
    if (rst0_req) mreset(0);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(1'b0);
  endtask

  task automatic wait_phase(input int off, input string tag);
    bit found = 0;
    for (int k = 0; k < 3000 && !found; k++) begin
      if (mT[0] >= 0 && mc[0] == mT[0] + off) found = 1;
      else step(1'b0);
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  initial begin
    int tt;
    rst0 = 1'b1; rst1 = 1'b1; ack0 = 1'b0; ack1 = 1'b0; en0 = 1'b0; en1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mreset(0); mreset(1);
    rst0 = 1'b0; rst1 = 1'b0;

    // Ack immediately, enable high: ticks at 999 and 1999.
    en_fix = 1; dly_fix = 0;
    run(2010);
    chk("last_tick", last_tick, 1999);
    chk("env_at_T1", last_env, 2000);
    chk("coef_at_T3", last_coef, 2002);
    chk("mac_start_T4", last_macs, 2003);
    chk("out_at_T9", last_out, 2008);
    chk("req_len_nodly", req_cnt, 1);

    // Ack delayed by 10 cycles.
    dly_fix = 10;
    run(1030);
    chk("out_at_T19", last_out, 2999 + 19);
    chk("req_len_dly10", req_cnt, 11);
    chk("no_overrun_dly", ovr0, 0);

    // Random ack latency and enable.
    dly_rand = 1; en_rand = 1;
    run(6000);
    dly_rand = 0; en_rand = 0;

    // Very slow ack: the next tick lands mid-frame (or times out with the macro).
    dly_fix = 1100;
    run(2500);
    dly_fix = 0;

    // Reset at T+5, then a complete frame at the next tick.
    wait_phase(5, "wait_T5");
    step(1'b1);
    chk("rst_env", env0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_ovr_cnt", cnt0, 0);
    run(1015);
    chk("post_rst_env", last_env, 1000);
    chk("post_rst_out", last_out, 1008);

    // Enable dropped at T+3: frame completes, next tick ignored.
    wait_phase(3, "wait_T3");
    tt = mT[0];
    en_fix = 0;
    run(1100);
    chk("endrop_out", last_out, tt + 9);
    chk("endrop_no_env", last_env, tt + 1);
    en_fix = 1;

`ifdef WAH_SEQ_TIMEOUT_EN
    // No ack at all: MAC starts at T+66 without a coefficient load.
    dly_fix = 1000000;
    wait_phase(1, "wait_tmo");
    tt = mT[0];
    run(80);
    chk("tmo_mac_start", last_macs, tt + 66);
    chk("tmo_no_coef", 32'(last_coef < tt), 32'd1);
    chk("tmo_flag", tmo0, 1);
    dly_fix = 0;
`endif

    chk("div8_saturated", cnt1, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
